// File: rtl/dmg_timer_pkg.sv
// rtl/dmg_timer_pkg.sv - shared types and constants for the DMG divider/timer
package dmg_timer_pkg;

    // CPU-visible register map
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        TIMA = 2'd1,
        TMA  = 2'd2,
        TAC  = 2'd3
    } timer_reg_t;

    // div_cnt bit tapped for each TAC[1:0] select value
    localparam int TAC_SEL_0 = 9;
    localparam int TAC_SEL_1 = 3;
    localparam int TAC_SEL_2 = 5;
    localparam int TAC_SEL_3 = 7;

    // Unused TAC bits [7:3] read back as ones
    localparam logic [7:0] TAC_UNUSED_MASK = 8'hF8;

endpackage

// File: rtl/dmg_timer_if.sv
// rtl/dmg_timer_if.sv - CPU register port of the divider/timer
interface dmg_timer_if;
    logic [1:0] addr;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (output addr, output wr, output din, input dout, input irq);
    modport slave  (input addr, input wr, input din, output dout, output irq);
endinterface

// File: rtl/dmg_timer_tap.sv
// rtl/dmg_timer_tap.sv - tap mux, enable gate and falling-edge tick detector
module dmg_timer_tap
    import dmg_timer_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] div_cnt_i,
    input  logic [2:0]  tac_i,
    output logic        tick_o
);

    logic sel_bit;
    logic tap_d;
    logic tap_q;

    // Select the divider bit that clocks TIMA
    always_comb begin
        sel_bit = 1'b0;
        case (tac_i[1:0])
            2'b00: sel_bit = div_cnt_i[TAC_SEL_0];
            2'b01: sel_bit = div_cnt_i[TAC_SEL_1];
            2'b10: sel_bit = div_cnt_i[TAC_SEL_2];
            2'b11: sel_bit = div_cnt_i[TAC_SEL_3];
            default: sel_bit = 1'b0;
        endcase
    end

    // Gating after the mux means DIV/TAC writes can produce a spurious falling edge
    assign tap_d = sel_bit & tac_i[2];

    // Remember last cycle's tap for the falling-edge compare
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tap_q <= 1'b0;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign tick_o = tap_q & ~tap_d;

endmodule

// File: rtl/dmg_timer.sv
// rtl/dmg_timer.sv - DIV/TIMA/TMA/TAC timer with delayed overflow reload
module dmg_timer
    import dmg_timer_pkg::*;
#(
    parameter int RELOAD_DELAY = 4
) (
    input  logic         clk,
    input  logic         nreset,
    dmg_timer_if.slave   bus
);

    localparam logic [2:0] RELOAD_INIT = 3'(RELOAD_DELAY);

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic [2:0]  rl_q, rl_d;
    logic        irq_q, irq_d;
    logic        tick;
    timer_reg_t  reg_sel;

    assign reg_sel = timer_reg_t'(bus.addr);

    dmg_timer_tap u_tap (
        .clk       (clk),
        .nreset    (nreset),
        .div_cnt_i (div_q),
        .tac_i     (tac_q),
        .tick_o    (tick)
    );

    // Next state: tick, then CPU write (wins over tick), then reload (wins over write)
    always_comb begin
        div_d  = div_q + 16'd1;
        tima_d = tima_q;
        tma_d  = tma_q;
        tac_d  = tac_q;
        rl_d   = rl_q;
        irq_d  = 1'b0;

        if (rl_q != 3'd0) begin
            rl_d = rl_q - 3'd1;
        end

        // Overflow only arms the reload when none is pending
        if (tick) begin
            if (tima_q == 8'hFF && rl_q == 3'd0) begin
                tima_d = 8'h00;
                rl_d   = RELOAD_INIT;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end

        if (bus.wr) begin
            case (reg_sel)
                DIV:  div_d = 16'h0000;
                TIMA: begin
                    tima_d = bus.din;
                    rl_d   = 3'd0;
                end
                TMA:  tma_d = bus.din;
                TAC:  tac_d = bus.din[2:0];
                default: ;
            endcase
        end

        // Reload edge: tma_d already carries a same-cycle TMA write
        if (rl_q == 3'd1) begin
            tima_d = tma_d;
            irq_d  = 1'b1;
            rl_d   = 3'd0;
        end
    end

    // Register all timer state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q  <= 16'h0000;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'd0;
            rl_q   <= 3'd0;
            irq_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            rl_q   <= rl_d;
            irq_q  <= irq_d;
        end
    end

    // Combinational read mux
    always_comb begin
        bus.dout = 8'h00;
        case (reg_sel)
            DIV:  bus.dout = div_q[15:8];
            TIMA: bus.dout = tima_q;
            TMA:  bus.dout = tma_q;
            TAC:  bus.dout = TAC_UNUSED_MASK | {5'b00000, tac_q};
            default: bus.dout = 8'h00;
        endcase
    end

    assign bus.irq = irq_q;

endmodule
